// File: rtl/vedic_mul_arbiter.sv
// Round-robin sharing of one combinational vedic 8x8 multiplier between NUM_REQ valid/ready requesters.
// Latency: accept edge -> product registered on the next edge -> response held in RESP until rsp_ready.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t1, t2, t3, c1;

  assign t1   = a[1] & b[0];
  assign t2   = a[0] & b[1];
  assign t3   = a[1] & b[1];
  assign c1   = t1 & t2;
  assign p[0] = a[0] & b[0];
  assign p[1] = t1 ^ t2;
  assign p[2] = t3 ^ c1;
  assign p[3] = t3 & c1;
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  // Vertically-and-crosswise recombination of the four partial products.
  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic_8x8_comb (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;

  vedic_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign p = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule

module vedic_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_p,
  output logic [IDX_W-1:0]     rsp_id,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [7:0]       op_a, op_b;
  logic [15:0]      product;
  logic             accept;

  // Search starts just past the last winner so it gets lowest priority.
  always_comb begin
    logic [IDX_W:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_REQ))
        idx = idx - (IDX_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[idx[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  vedic_8x8_comb u_mul (.a(op_a), .b(op_b), .p(product));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MUL;
      MUL:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= IDX_W'(NUM_REQ - 1);
      op_a   <= '0;
      op_b   <= '0;
      rsp_id <= '0;
      rsp_p  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        op_a   <= req_a[grant_idx*8 +: 8];
        op_b   <= req_b[grant_idx*8 +: 8];
        rsp_id <= grant_idx;
        rr_ptr <= grant_idx;
      end
      if (state == MUL)
        rsp_p <= product;
    end
  end
endmodule
